// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus for the fetch stage.
//   imem_req   : one-cycle request pulse from the fetch unit
//   imem_addr  : fetch address, valid with imem_req
//   imem_rdata : returned instruction word
//   imem_valid : one-cycle pulse qualifying imem_rdata
interface fetch_unit_if;
  localparam int unsigned XLEN = 16;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to a
// variable-latency instruction memory, and buffers one returned instruction
// until the IF/ID register accepts it. Handles stall, redirect and halt.
//   clk, rst     : clock, synchronous active-high reset
//   stall        : hold IF/ID contents (gates if_id_we, blocks refill)
//   redirect     : taken branch / flush; redirect_pc is the new fetch PC
//   imem         : instruction-memory bus (master side)
//   inst_out     : instruction for IF/ID (NOP_INST when none)
//   pc_out       : address of inst_out; pc_next_out = pc_out + PC_INC
//   if_id_we     : IF/ID write enable
//   halted       : halt opcode fetched, no further requests
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2,
  parameter logic [15:0] NOP_INST = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [15:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic [15:0]         inst_out,
  output logic [15:0]         pc_out,
  output logic [15:0]         pc_next_out,
  output logic                if_id_we,
  output logic                halted
);

  localparam int unsigned XLEN = 16;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            buf_valid;
  logic [XLEN-1:0] buf_inst;
  logic [XLEN-1:0] buf_pc;
  logic            can_issue;
  logic            is_halt_op;

  // A new request is allowed only if the buffer will be free when data returns.
  assign can_issue  = ~buf_valid | ~stall;
  assign is_halt_op = (imem.imem_rdata[15:12] == HALT_OP);

  // State, PC and instruction buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      buf_valid <= 1'b0;
      buf_inst  <= NOP_INST;
      buf_pc    <= '0;
      halted    <= 1'b0;
    end else if (redirect) begin
      // Squash everything; an in-flight request must still be drained.
      pc        <= redirect_pc;
      buf_valid <= 1'b0;
      halted    <= 1'b0;
      state     <= (state == S_WAIT && !imem.imem_valid) ? S_DROP : S_REQ;
    end else begin
      if (buf_valid && !stall) begin
        buf_valid <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (can_issue) begin
            pc    <= pc + PC_INC;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_valid) begin
            buf_inst  <= imem.imem_rdata;
            buf_pc    <= pc - PC_INC;
            buf_valid <= 1'b1;
            if (is_halt_op) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_DROP: begin
          if (imem.imem_valid) begin
            state <= S_REQ;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

  // Memory request and IF/ID-facing outputs.
  assign imem.imem_req  = (state == S_REQ) && can_issue && !redirect;
  assign imem.imem_addr = pc;

  assign inst_out    = (buf_valid && !redirect) ? buf_inst : NOP_INST;
  assign pc_out      = buf_valid ? buf_pc : XLEN'(0);
  assign pc_next_out = pc_out + PC_INC;
  assign if_id_we    = ~stall;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0000;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
    logic [15:0] nxt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] inst_out;
  logic [15:0] pc_out;
  logic [15:0] pc_next_out;
  logic        if_id_we;
  logic        halted;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .pc_next_out (pc_next_out),
    .if_id_we    (if_id_we),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  // Instruction memory contents seen by the bench.
  function automatic logic [15:0] memf(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0002: return 16'h2222;
      16'h0004: return 16'h3333;
      16'h0006: return 16'h6666;
      16'h0010: return 16'hF000;
      16'h0020: return 16'h2020;
      16'h0040: return 16'h4040;
      16'hFFFE: return 16'hEEEE;
      default:  return 16'h5000 | {4'h0, a[11:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pipelined memory model with programmable latency (cycles).
  int          lat = 1;
  int          cyc = 0;
  logic        sv[64];
  logic [15:0] sd[64];

  initial begin
    for (int i = 0; i < 64; i++) begin
      sv[i] = 1'b0;
      sd[i] = '0;
    end
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_bus.imem_valid = sv[cyc % 64];
      imem_bus.imem_rdata = sd[cyc % 64];
      sv[cyc % 64] = 1'b0;
      if (imem_bus.imem_req === 1'b1) begin
        sv[(cyc + lat) % 64] = 1'b1;
        sd[(cyc + lat) % 64] = memf(imem_bus.imem_addr);
      end
    end
  end

  // Scoreboard: every real IF/ID write must match the next expected entry.
  always @(negedge clk) begin
    if (mon_en && if_id_we === 1'b1 && inst_out !== NOP) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", inst_out, NOP);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_inst", inst_out, e.inst);
        chk("wr_pc", pc_out, e.pc);
        chk("wr_next", pc_next_out, e.nxt);
      end
    end
  end

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    sb.push_back('{16'h1111, 16'h0000, 16'h0002});
    sb.push_back('{16'h2222, 16'h0002, 16'h0004});

    // Reset state
    mid();
    chk("rst_inst", inst_out, NOP);
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_next", pc_next_out, 16'h0002);
    chk("rst_we", 16'(if_id_we), 16'd1);
    chk("rst_req", 16'(imem_bus.imem_req), 16'd1);
    chk("rst_addr", imem_bus.imem_addr, 16'h0000);
    chk("rst_halted", 16'(halted), 16'd0);

    // Gap cycle while waiting for the first word
    nc(); mid();
    chk("gap_req", 16'(imem_bus.imem_req), 16'd0);
    chk("gap_inst", inst_out, NOP);
    chk("gap_we", 16'(if_id_we), 16'd1);
    nc(); mid();
    chk("seq_req1", 16'(imem_bus.imem_req), 16'd1);
    chk("seq_addr1", imem_bus.imem_addr, 16'h0002);
    nc(); mid();
    chk("gap2_inst", inst_out, NOP);
    nc(); mid();
    chk("seq_req2", 16'(imem_bus.imem_req), 16'd1);
    chk("seq_addr2", imem_bus.imem_addr, 16'h0004);
    sb.push_back('{16'h3333, 16'h0004, 16'h0006});
    nc(); mid();

    // Stall with 3333 held in the buffer
    for (int i = 0; i < 3; i++) begin
      nc(); stall = 1'b1; mid();
      chk("stall_we", 16'(if_id_we), 16'd0);
      chk("stall_req", 16'(imem_bus.imem_req), 16'd0);
      chk("stall_inst", inst_out, 16'h3333);
    end
    nc(); stall = 1'b0; lat = 3; mid();
    chk("release_req", 16'(imem_bus.imem_req), 16'd1);
    chk("release_addr", imem_bus.imem_addr, 16'h0006);
    chk("release_we", 16'(if_id_we), 16'd1);

    // Redirect while waiting on a 3-cycle memory
    nc(); redirect = 1'b1; redirect_pc = 16'h0040; mid();
    chk("redir_inst", inst_out, NOP);
    chk("redir_req", 16'(imem_bus.imem_req), 16'd0);
    nc(); redirect = 1'b0; lat = 1; mid();
    chk("drop_req1", 16'(imem_bus.imem_req), 16'd0);
    nc(); mid();
    chk("drop_req2", 16'(imem_bus.imem_req), 16'd0);
    nc(); mid();
    chk("redir_req_new", 16'(imem_bus.imem_req), 16'd1);
    chk("redir_addr_new", imem_bus.imem_addr, 16'h0040);
    nc(); mid();

    // Redirect with 4040 buffered: it is squashed
    nc(); redirect = 1'b1; redirect_pc = 16'h0010; mid();
    chk("squash_inst", inst_out, NOP);
    chk("squash_req", 16'(imem_bus.imem_req), 16'd0);
    nc(); redirect = 1'b0; mid();
    sb.push_back('{16'hF000, 16'h0010, 16'h0012});
    chk("halt_fetch_req", 16'(imem_bus.imem_req), 16'd1);
    chk("halt_fetch_addr", imem_bus.imem_addr, 16'h0010);
    nc(); mid();
    nc(); mid();
    chk("halted_set", 16'(halted), 16'd1);
    chk("halted_req", 16'(imem_bus.imem_req), 16'd0);
    for (int i = 0; i < 10; i++) begin
      nc(); mid();
      chk("halt_idle_req", 16'(imem_bus.imem_req), 16'd0);
      chk("halt_idle_flag", 16'(halted), 16'd1);
    end

    // Leave halt by redirect
    nc(); redirect = 1'b1; redirect_pc = 16'h0020; mid();
    chk("unhalt_flag_hold", 16'(halted), 16'd1);
    nc(); redirect = 1'b0; mid();
    sb.push_back('{16'h2020, 16'h0020, 16'h0022});
    chk("unhalt_flag", 16'(halted), 16'd0);
    chk("unhalt_req", 16'(imem_bus.imem_req), 16'd1);
    chk("unhalt_addr", imem_bus.imem_addr, 16'h0020);
    nc(); mid();
    nc(); mid();
    chk("after2020_req", 16'(imem_bus.imem_req), 16'd1);
    chk("after2020_addr", imem_bus.imem_addr, 16'h0022);

    // Redirect in the same cycle as returning data: data dropped, no DROP state
    nc(); redirect = 1'b1; redirect_pc = 16'hFFFE; mid();
    nc(); redirect = 1'b0; mid();
    sb.push_back('{16'hEEEE, 16'hFFFE, 16'h0000});
    chk("wrap_req", 16'(imem_bus.imem_req), 16'd1);
    chk("wrap_addr", imem_bus.imem_addr, 16'hFFFE);
    nc(); mid();
    nc(); lat = 2; mid();
    chk("wrap_next", pc_next_out, 16'h0000);
    chk("wrap_req2", 16'(imem_bus.imem_req), 16'd1);
    chk("wrap_addr2", imem_bus.imem_addr, 16'h0000);

    // Reset mid-WAIT; the late response lands in REQ and is ignored
    nc(); rst = 1'b1; mid();
    chk("rstw_req", 16'(imem_bus.imem_req), 16'd0);
    nc(); rst = 1'b0; mid();
    sb.push_back('{16'h1111, 16'h0000, 16'h0002});
    chk("rst2_req", 16'(imem_bus.imem_req), 16'd1);
    chk("rst2_addr", imem_bus.imem_addr, 16'h0000);
    chk("rst2_inst", inst_out, NOP);
    chk("rst2_pc", pc_out, 16'h0000);
    nc(); mid();
    chk("late_ignored_inst", inst_out, NOP);
    chk("late_ignored_pc", pc_out, 16'h0000);
    nc(); mid();
    nc(); mid();
    nc(); mid();
    chk("sb_empty", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit 5-stage pipeline; sits directly upstream of the IF/ID pipeline register and drives its inst, pc and write_enable inputs.
- Owns the PC register and issues one request at a time to a variable-latency instruction memory.
- Holds the returned instruction in a one-entry buffer until IF/ID accepts it.
- Handles stall, branch redirect/flush and halt.

Parameters:
RESET_PC, 16'h0000, PC loaded by reset
PC_INC, 2, byte increment per instruction
NOP_INST, 16'h0000, bubble driven into IF/ID when no valid instruction
HALT_OP, 4'hF, opcode (inst[15:12]) that stops fetching

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
stall  in  1  hazard unit: hold IF/ID contents
redirect  in  1  taken branch/flush from later stage
redirect_pc  in  16  target PC when redirect=1
imem_req  out  1  request pulse to instruction memory
imem_addr  out  16  fetch address, valid with imem_req
imem_rdata  in  16  returned instruction
imem_valid  in  1  imem_rdata valid (1-cycle pulse, ≥1 cycle after imem_req)
inst_out  out  16  to IF/ID inst_in
pc_out  out  16  address of inst_out
pc_next_out  out  16  pc_out + PC_INC (mod 2^16)
if_id_we  out  1  to IF/ID write_enable
halted  out  1  halt instruction fetched; no further requests

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- State: pc[15:0] holds next fetch address; one-entry buffer buf_valid/buf_inst/buf_pc; FSM states REQ, WAIT, DROP, HALT.
- Reset (rst=1 at edge): pc=RESET_PC, buf_valid=0, halted=0, state=REQ.
  - Outputs after the reset edge: inst_out=NOP_INST, pc_out=0, pc_next_out=PC_INC, if_id_we=1, imem_req=1 (REQ with empty buffer).
  - rst overrides all other inputs, including mid-WAIT; a late imem_valid for a pre-reset request arrives in REQ and is ignored.
- Output data:
  - inst_out = buf_valid ? buf_inst : NOP_INST.
  - pc_out = buf_pc (0 when buf_valid=0).
  - if_id_we = ~stall.
  - If redirect=1: inst_out forced to NOP_INST (wrong-path squash).
- Consume: the buffer empties at an edge where buf_valid=1 and stall=0. A capture at the same edge refills it.
- can_issue = ~buf_valid | ~stall.
- REQ:
  - imem_req = can_issue & ~redirect; imem_addr = pc.
  - On issue: pc <= pc + PC_INC (wraps FFFE→0000), go WAIT. Otherwise stay.
- WAIT:
  - imem_req=0.
  - On imem_valid: buf_inst <= imem_rdata, buf_pc <= pc - PC_INC, buf_valid <= 1.
    - If imem_rdata[15:12]==HALT_OP: halted <= 1, go HALT.
    - Else go REQ.
  - The buffer is guaranteed free on arrival (issue rule); the halt instruction itself is delivered normally.
- DROP: waits for the imem_valid of the squashed request, discards its data, then goes REQ. imem_req=0.
- HALT: no requests; buffer drains normally. Leaves only on redirect or rst.
- Redirect (any state except during rst), at the edge:
  - pc <= redirect_pc, buf_valid <= 0, halted <= 0.
  - Next state: DROP if in WAIT and imem_valid=0 this cycle; else REQ.
  - Data arriving in the same cycle as redirect is discarded.
  - redirect wins over stall; stall only gates if_id_we.
- Simultaneous stall & imem_valid: capture proceeds; the buffer holds until stall drops.
- Latency: reset→first IF/ID valid write = 1 + memory latency + 1 edges. Steady state with 1-cycle memory: one instruction per 2 cycles (single outstanding request).

Test Plan:
- Reset, 1-cycle imem returning 16'h1111, 16'h2222 → imem_addr 0000 then 0002; IF/ID receives (1111, pc 0000, next 0002) then (2222, 0002, 0004); NOP_INST with if_id_we=1 in gap cycles.
- Buffer 16'h3333 valid, stall=1 for 3 cycles → if_id_we=0 for 3 cycles, no new imem_req; after release, 3333 is written once and the next request is issued in that cycle.
- Redirect to 16'h0040 while in WAIT (3-cycle memory) → returning data discarded (DROP), next imem_addr=0040, inst_out=NOP_INST during the redirect cycle.
- Fetch 16'hF000 at 0010 → halted=1, F000 delivered with pc 0010, no imem_req for 10 cycles; redirect to 0020 → halted=0, imem_addr=0020.
- pc=FFFE fetch → pc_next_out=0000, next imem_addr=0000.
- rst asserted mid-WAIT with late imem_valid → ignored; next imem_addr=RESET_PC, buf_valid=0.
